uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_if.sv | 25 ++
 rtl/uart_baud_gen.sv | 88 ++++++++
 tb/tb_uart_baud_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_if.sv
// Control and tick bundle between the UART TX/RX paths and the baud/oversample generator.
interface uart_baud_if #(
  parameter int DIV_W  = 12,
  parameter int FRAC_W = 4
);
  logic              en;
  logic              cfg_load;
  logic [DIV_W-1:0]  div_i;
  logic [FRAC_W-1:0] frac_i;
  logic              sync;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              baud_clk;

  modport master (
    output en, cfg_load, div_i, frac_i, sync,
    input  os_tick, bit_tick, mid_tick, baud_clk
  );

  modport slave (
    input  en, cfg_load, div_i, frac_i, sync,
    output os_tick, bit_tick, mid_tick, baud_clk
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N oversample tick generator with bit, mid-bit and legacy square-wave baud outputs.
module uart_baud_gen #(
  parameter int DIV_W    = 12,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_DIV  = 325,
  parameter int DEF_FRAC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_baud_if.slave  bus
);
  localparam int CNT_W = DIV_W + 1;
  localparam int OSC_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0]  CNT_RST  = CNT_W'((DEF_DIV == 0) ? 1 : DEF_DIV);
  localparam logic [OSC_W-1:0]  OS_LAST  = OSC_W'(OSR - 1);
  localparam logic [OSC_W-1:0]  OS_MID   = OSC_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [DIV_W-1:0]  div_a;
  logic [FRAC_W-1:0] frac_a;
  logic [FRAC_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [OSC_W-1:0]  os_cnt;

  logic [CNT_W-1:0]  div_eff;
  logic [CNT_W-1:0]  div_new_eff;
  logic [FRAC_W:0]   acc_sum;
  logic              expire;

  function automatic logic [CNT_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? CNT_ONE : {1'b0, d};
  endfunction

  always_comb begin
    div_eff     = eff_div(div_a);
    div_new_eff = eff_div(bus.div_i);
    acc_sum     = {1'b0, acc} + {1'b0, frac_a};
    expire      = (cnt == CNT_ONE);
  end

  // cnt holds the remaining cycles of the current period; a period ends when it reaches 1,
  // so loading the period length gives a tick on the period-length-th enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a        <= DIV_W'(DEF_DIV);
      frac_a       <= FRAC_W'(DEF_FRAC);
      acc          <= FRAC_W'(DEF_FRAC);
      cnt          <= CNT_RST;
      os_cnt       <= '0;
      bus.os_tick  <= 1'b0;
      bus.bit_tick <= 1'b0;
      bus.mid_tick <= 1'b0;
      bus.baud_clk <= 1'b0;
    end else begin
      bus.os_tick  <= 1'b0;
      bus.bit_tick <= 1'b0;
      bus.mid_tick <= 1'b0;
      if (bus.cfg_load) begin
        div_a  <= bus.div_i;
        frac_a <= bus.frac_i;
        acc    <= bus.frac_i;
        cnt    <= div_new_eff;
        os_cnt <= '0;
      end else if (bus.sync) begin
        acc    <= frac_a;
        cnt    <= div_eff;
        os_cnt <= '0;
      end else if (bus.en) begin
        if (expire) begin
          acc          <= acc_sum[FRAC_W-1:0];
          cnt          <= div_eff + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
          bus.os_tick  <= 1'b1;
          bus.bit_tick <= (os_cnt == OS_LAST);
          bus.mid_tick <= (os_cnt == OS_MID);
          if (os_cnt == OS_LAST) begin
            os_cnt       <= '0;
            bus.baud_clk <= ~bus.baud_clk;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench: a closed-form tick-time model predicts every tick; a negedge monitor checks them.
module tb_uart_baud_gen;
  localparam int DIV_W    = 12;
  localparam int FRAC_W   = 4;
  localparam int OSR      = 16;
  localparam int DEF_DIV  = 325;
  localparam int DEF_FRAC = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_baud_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  uart_baud_gen #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEF_DIV(DEF_DIV), .DEF_FRAC(DEF_FRAC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    longint cyc;
    bit     b;
    bit     m;
    bit     baud;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  // Model: after a restart, the k-th tick lands on enabled edge k*d + floor(k*f / 2^FRAC_W).
  longint m_d, m_f, m_e, m_k, m_bits;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint tk(input longint k);
    return k * m_d + ((k * m_f) >> FRAC_W);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_d = DEF_DIV; m_f = DEF_FRAC; m_e = 0; m_k = 0; m_bits = 0;
    q.delete();
  endtask

  task automatic step(input bit e, input bit ld, input int dv, input int fr, input bit sy);
    bit b;
    @(negedge clk);
    bus.en       = e;
    bus.cfg_load = ld;
    bus.div_i    = DIV_W'(dv);
    bus.frac_i   = FRAC_W'(fr);
    bus.sync     = sy;
    if (ld) begin
      m_d = (dv == 0) ? 1 : dv; m_f = fr; m_e = 0; m_k = 0;
    end else if (sy) begin
      m_e = 0; m_k = 0;
    end else if (e) begin
      m_e++;
      if (m_e == tk(m_k + 1)) begin
        m_k++;
        b = (m_k % OSR) == 0;
        if (b) m_bits++;
        q.push_back('{cyc + 1, b, (m_k % OSR) == OSR / 2, m_bits[0]});
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++; n_fail++;
        $display("FAIL missed_tick: got none expected tick at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.os_tick || bus.bit_tick || bus.mid_tick) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_tick: got os/bit/mid=%b%b%b at cycle %0d expected none",
                   bus.os_tick, bus.bit_tick, bus.mid_tick, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.cyc != cyc || !bus.os_tick || bus.bit_tick != e.b || bus.mid_tick != e.m
              || bus.baud_clk != e.baud) begin
            n_fail++;
            $display("FAIL tick: got cyc=%0d os=%b bit=%b mid=%b baud=%b expected cyc=%0d os=1 bit=%b mid=%b baud=%b",
                     cyc, bus.os_tick, bus.bit_tick, bus.mid_tick, bus.baud_clk,
                     e.cyc, e.b, e.m, e.baud);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.sync = 1'b0;
    bus.div_i = '0; bus.frac_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_os_tick", bus.os_tick, 0);
    chk("rst_bit_tick", bus.bit_tick, 0);
    chk("rst_mid_tick", bus.mid_tick, 0);
    chk("rst_baud_clk", bus.baud_clk, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // div 4 / frac 0, then 4 / 8 (alternating 4,5 periods)
    step(1'b0, 1'b1, 4, 0, 1'b0);
    run(300);
    step(1'b1, 1'b1, 4, 8, 1'b0);
    run(4600);

    // defaults 325.5
    step(1'b1, 1'b1, DEF_DIV, DEF_FRAC, 1'b0);
    run(11000);

    // sync mid-bit: 7 ticks done at 28, cnt half-way at 30
    step(1'b1, 1'b1, 4, 0, 1'b0);
    run(29);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    run(300);

    // en dropped for 10 cycles mid-period
    run(50);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    run(300);

    // div 0 behaves as 1; div 1 with fraction gives 2-cycle carry periods
    step(1'b1, 1'b1, 0, 0, 1'b0);
    run(100);
    step(1'b1, 1'b1, 0, 5, 1'b0);
    run(200);
    step(1'b1, 1'b1, 1, 15, 1'b0);
    run(100);

    // cfg_load with en low, counting starts when en rises
    step(1'b0, 1'b1, 3, 4, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    run(200);

    // async reset mid-run while os_tick is high every cycle
    step(1'b1, 1'b1, 1, 0, 1'b0);
    run(40);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_os_tick", bus.os_tick, 0);
    chk("async_bit_tick", bus.bit_tick, 0);
    chk("async_mid_tick", bus.mid_tick, 0);
    chk("async_baud_clk", bus.baud_clk, 0);
    model_reset();
    repeat (2) @(negedge clk);
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.sync = 1'b0;
    rst_n = 1'b1;
    run(6000);

    // randomized segments
    for (int s = 0; s < 20; s++) begin
      step(1'b1, 1'b1, $urandom_range(0, 9), $urandom_range(0, 15), 1'b0);
      for (int i = 0; i < 500; i++)
        step(($urandom % 8) != 0, ($urandom % 400) == 0, $urandom_range(0, 9),
             $urandom_range(0, 15), ($urandom % 97) == 0);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
